// File: rtl/pipe_shifter.sv
// ---------------------------------------------------------------------------
// pipe_shifter
//
// Pipelined barrel shifter for the datapath ALU. One shift level is
// applied per pipeline stage: stage k shifts by 2^k when the shift-amount
// bit it is given is set, and passes the value through otherwise. A
// single global advance enable moves the whole pipe one stage at a time,
// so every stage either advances together or holds together.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   input beat present
//   in_ready   block can accept a beat this cycle (combinational from
//              out_valid / out_ready)
//   in_data    operand, WIDTH bits
//   in_shamt   shift amount, SHW bits (0 .. WIDTH-1)
//   in_op      0 pass, 1 sll, 2 srl, 3 sra, 4 rol, 5 ror, 6/7 illegal
//   out_valid  result beat present
//   out_ready  consumer accepts the result this cycle
//   out_data   shifted result, WIDTH bits
//   out_zero   out_data == 0 (meaningful while out_valid = 1)
//   out_err    the beat carried an illegal op (data passed unchanged)
// ---------------------------------------------------------------------------
module pipe_shifter #(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_err
);

    typedef enum logic [2:0] {
        OP_PASS = 3'd0,
        OP_SLL  = 3'd1,
        OP_SRL  = 3'd2,
        OP_SRA  = 3'd3,
        OP_ROL  = 3'd4,
        OP_ROR  = 3'd5
    } op_e;

    // Per-stage registers. The last stage keeps only data and valid, and
    // folds its op into the registered err flag; the stages before it also
    // carry op, original sign and the not-yet-consumed shift-amount bits.
    logic [WIDTH-1:0] data_q  [SHW];
    logic [SHW-1:0]   valid_q;
    logic [2:0]       op_q    [SHW-1];
    logic [SHW-2:0]   sign_q;
    logic [SHW-1:0]   shamt_q [SHW-1];
    logic             err_q;
    logic             zero_q;

    // Stage inputs (from in_* for stage 0, from the previous stage
    // otherwise) and the shifted value each stage would load.
    logic [WIDTH-1:0] src_data  [SHW];
    logic [2:0]       src_op    [SHW];
    logic [SHW-1:0]   src_sign;
    logic [SHW-1:0]   src_shamt [SHW];
    logic [WIDTH-1:0] nxt_data  [SHW];

    logic adv;

    // One shift level. Arithmetic right shift fills with the sign of the
    // original operand, which travels down the pipe, never with the MSB
    // of an intermediate value. Pass and the illegal ops leave data as is.
    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input logic             sign,
        input logic [2:0]       op,
        input logic             en,
        input int               amt
    );
        logic [WIDTH-1:0] ones;
        logic [WIDTH-1:0] r;
        ones = '1;
        r    = d;
        if (en) begin
            case (op)
                OP_SLL:  r = d << amt;
                OP_SRL:  r = d >> amt;
                OP_SRA:  r = (d >> amt) | (sign ? ~(ones >> amt) : '0);
                OP_ROL:  r = (d << amt) | (d >> (WIDTH - amt));
                OP_ROR:  r = (d >> amt) | (d << (WIDTH - amt));
                default: r = d;
            endcase
        end
        return r;
    endfunction

    // The whole pipe advances whenever the output slot is empty or being
    // drained; this is also the only input-to-output combinational path.
    assign adv       = !out_valid || out_ready;
    assign in_ready  = adv;
    assign out_valid = valid_q[SHW-1];
    assign out_data  = data_q[SHW-1];
    assign out_zero  = zero_q;
    assign out_err   = err_q;

    // Stage input selection and per-stage shift. Each stage consumes bit 0
    // of the shift amount it receives and hands the remaining bits on,
    // shifted down by one, so stage k always looks at original bit k.
    always_comb begin
        src_data[0]  = in_data;
        src_op[0]    = in_op;
        src_sign[0]  = in_data[WIDTH-1];
        src_shamt[0] = in_shamt;
        for (int k = 1; k < SHW; k++) begin
            src_data[k]  = data_q[k-1];
            src_op[k]    = op_q[k-1];
            src_sign[k]  = sign_q[k-1];
            src_shamt[k] = shamt_q[k-1];
        end
        for (int k = 0; k < SHW; k++) begin
            nxt_data[k] = shift_level(src_data[k], src_sign[k], src_op[k],
                                      src_shamt[k][0], 1 << k);
        end
    end

    // Pipeline registers. Reset clears everything, including data, so the
    // outputs read 0 rather than X. Stage 0 only samples operands on an
    // accepted beat; later stages advance bubbles exactly like full beats.
    // The zero and error flags are produced in the last stage from the
    // final data and the op that travelled with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            sign_q  <= '0;
            err_q   <= 1'b0;
            zero_q  <= 1'b0;
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= '0;
            end
            for (int k = 0; k < SHW - 1; k++) begin
                op_q[k]    <= '0;
                shamt_q[k] <= '0;
            end
        end else if (adv) begin
            valid_q <= {valid_q[SHW-2:0], in_valid};
            if (in_valid) begin
                data_q[0]  <= nxt_data[0];
                op_q[0]    <= src_op[0];
                sign_q[0]  <= src_sign[0];
                shamt_q[0] <= src_shamt[0] >> 1;
            end
            for (int k = 1; k < SHW; k++) begin
                data_q[k] <= nxt_data[k];
            end
            for (int k = 1; k < SHW - 1; k++) begin
                op_q[k]    <= src_op[k];
                sign_q[k]  <= src_sign[k];
                shamt_q[k] <= src_shamt[k] >> 1;
            end
            err_q  <= src_op[SHW-1][2] & src_op[SHW-1][1];
            zero_q <= (nxt_data[SHW-1] == '0);
        end
    end

endmodule

// File: doc/pipe_shifter.md
# pipe_shifter

Parametrised, pipelined barrel shifter for the datapath ALU. It is the next generation of the 16-bit combinational shifter. It generalises data width and adds rotate modes and a defined illegal-op response. It registers one shift level per pipeline stage and carries a valid/ready handshake, so it can sit between the issue stage and writeback at higher clock rates.

## Interface
- WIDTH, 16, data width; power of two, 4 to 64.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat this cycle.
- in_data  in  WIDTH  operand.
- in_shamt  in  SHW  shift amount, 0 to WIDTH-1.
- in_op  in  3  0 pass, 1 sll, 2 srl, 3 sra, 4 rol, 5 ror, 6/7 illegal.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result this cycle.
- out_data  out  WIDTH  shifted result.
- out_zero  out  1  out_data == 0.
- out_err  out  1  the beat carried an illegal op.

## Operation
- The block has SHW pipeline stages. Stage k applies a shift of 2^k when shamt bit k = 1, otherwise it passes the value through.
- Each stage registers: data, remaining shamt bits, op, original sign bit, valid.
- Stage 0 takes its input from in_*. Stage SHW-1 drives out_*.
- sll: zero-fill from the LSB.
- srl: zero-fill from the MSB.
- sra: fill from the MSB with the sign bit of the original in_data. The sign bit is carried down the pipe and is never taken from an intermediate stage.
- rol / ror: bits shifted out of one end re-enter at the other end. There is no fill.
- pass (op 0): data is unchanged regardless of shamt.
- Illegal op (6 or 7): data passes unchanged, out_err = 1. The result is never X.
- shamt = 0 gives identity for every op.
- out_zero is computed in the last stage from the final data. It is valid whenever out_valid = 1.
- Stall control is a single global enable: adv = !out_valid || out_ready.
  - in_ready = adv.
  - When adv = 0, every stage register holds its value.
  - When adv = 1, every stage loads from its predecessor. Stage 0 loads in_valid.
- Bubbles are not compressed. Empty stages advance like full ones.
- A beat is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready.
- Results leave in acceptance order. No beat is dropped or duplicated.

## Timing
- Latency: a beat accepted at the end of cycle 0 shows out_valid = 1 in cycle SHW (cycle 4 for WIDTH = 16). This assumes no stall.
- Throughput: one beat per cycle while out_ready = 1.
- in_ready is combinational from out_valid and out_ready. No other input-to-output combinational path exists.
- The data and control inputs (in_data, in_shamt, in_op) are sampled only when a beat is accepted.
- out_* hold their values, unchanged, while out_valid && !out_ready.
- When the pipe is full and out_ready = 1, a new input is accepted in the same cycle the oldest result leaves.
- Reset (rst_n = 0 at a rising edge):
  - All stage valids clear, so out_valid = 0 in the next cycle.
  - out_data, out_zero and out_err read 0. Data registers are reset as well, so no X appears.
  - Beats in flight are discarded.
  - in_ready = 1 in the cycle after reset.
  - Reset takes priority over a simultaneous accept or consume.

## Test plan
- Directed ops, WIDTH = 16, in_data 0x8001. Required results:
  - sll 1 -> 0x0002
  - srl 4 -> 0x0800
  - sra 1 -> 0xC000
  - sra 15 -> 0xFFFF
  - rol 1 -> 0x0003
  - ror 4 -> 0x1800
  - pass 7 -> 0x8001
  - each with out_err = 0
- Boundaries:
  - srl 0x0001 by 1 -> 0x0000, out_zero = 1.
  - sra 0x7FFF by 15 -> 0x0000.
  - Any op with shamt 0 -> data unchanged.
- Illegal op 6 and op 7 on 0x1234 -> out_data 0x1234, out_err = 1, no X on any output.
- Streaming: 8 back-to-back beats with out_ready = 1 -> first result in cycle 4, then one result per cycle, in order.
- Backpressure: with out_ready held low for 3 cycles mid-stream:
  - in_ready = 0 during the stall.
  - out_data is stable during the stall.
  - All 8 results arrive, in order.
- Reset mid-stream: rst_n = 0 for one edge with 3 beats in flight -> out_valid = 0 in the next cycle, none of the 3 results ever appear, a new beat is accepted in the following cycle.
- Parameter sweep at WIDTH = 8 and WIDTH = 32: random op/shamt/data checked against a reference model -> latency equals SHW (3 and 5).
